// File: rtl/cp0_pkg.sv
// Shared constants and types for the CP0 exception sequencer.
// Optional feature macro: CP0_EXC_COUNT_EN (exception counter at CP0 index 22).
package cp0_pkg;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_0180;

    // CP0 register indices
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_COUNT    = 5'd22;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DIVZ = 5'd13;

    // Status bit positions
    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRedirect
    } exc_state_e;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline-facing bundle of the exception sequencer: fault inputs, MTC0/MFC0 port,
// flush controls and the fetch redirect handshake.
interface cp0_exc_ctrl_if;
    logic        id_fault;
    logic        ex_fault;
    logic [31:0] ex_addr;
    logic        ext_irq;
    logic [31:0] pc_d;
    logic [31:0] pc_e;
    logic        eret_d;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush_d;
    logic        flush_e;
    logic        flush_m;
    logic        flush_w;
    logic        wb_disable;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ack;
    logic        busy;

    // Pipeline side
    modport master (
        output id_fault, ex_fault, ex_addr, ext_irq, pc_d, pc_e, eret_d,
               cp0_we, cp0_addr, cp0_wdata, redir_ack,
        input  cp0_rdata, flush_d, flush_e, flush_m, flush_w, wb_disable,
               redir_valid, redir_pc, busy
    );

    // Exception sequencer side
    modport slave (
        input  id_fault, ex_fault, ex_addr, ext_irq, pc_d, pc_e, eret_d,
               cp0_we, cp0_addr, cp0_wdata, redir_ack,
        output cp0_rdata, flush_d, flush_e, flush_m, flush_w, wb_disable,
               redir_valid, redir_pc, busy
    );
endinterface

// File: rtl/cp0_regfile.sv
// Architected CP0 exception registers with MTC0 write port, exception/ERET update
// port and combinational read mux. CP0_EXC_COUNT_EN adds a saturating take counter.
module cp0_regfile
    import cp0_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        take_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] epc_i,
    input  logic        badv_we_i,
    input  logic [31:0] badv_i,
    input  logic        eret_i,
    output logic        ie_o,
    output logic        exl_o,
    output logic [31:0] epc_o
);

    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badv_q, badv_d;
`ifdef CP0_EXC_COUNT_EN
    logic [31:0] count_q, count_d;
`endif

    // Next state: MTC0 first, hardware updates override it
    always_comb begin
        ie_d   = ie_q;
        exl_d  = exl_q;
        code_d = code_q;
        epc_d  = epc_q;
        badv_d = badv_q;
`ifdef CP0_EXC_COUNT_EN
        count_d = count_q;
`endif
        if (we_i) begin
            case (addr_i)
                CP0_BADVADDR: badv_d = wdata_i;
                CP0_STATUS: begin
                    ie_d  = wdata_i[STATUS_IE];
                    exl_d = wdata_i[STATUS_EXL];
                end
                CP0_CAUSE:    code_d = wdata_i[6:2];
                CP0_EPC:      epc_d  = wdata_i;
`ifdef CP0_EXC_COUNT_EN
                CP0_COUNT:    count_d = wdata_i;
`endif
                default: ;
            endcase
        end
        if (take_i) begin
            ie_d   = ie_q;
            exl_d  = 1'b1;
            code_d = exc_code_i;
            epc_d  = epc_i;
            if (badv_we_i) begin
                badv_d = badv_i;
            end
`ifdef CP0_EXC_COUNT_EN
            count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
`endif
        end else if (eret_i) begin
            ie_d  = ie_q;
            exl_d = 1'b0;
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ie_q   <= 1'b0;
            exl_q  <= 1'b0;
            code_q <= '0;
            epc_q  <= '0;
            badv_q <= '0;
`ifdef CP0_EXC_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            code_q <= code_d;
            epc_q  <= epc_d;
            badv_q <= badv_d;
`ifdef CP0_EXC_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

    // MFC0 read mux, no bypass of a same-cycle write
    always_comb begin
        rdata_o = '0;
        case (addr_i)
            CP0_BADVADDR: rdata_o = badv_q;
            CP0_STATUS:   rdata_o = {30'd0, exl_q, ie_q};
            CP0_CAUSE:    rdata_o = {25'd0, code_q, 2'b00};
            CP0_EPC:      rdata_o = epc_q;
`ifdef CP0_EXC_COUNT_EN
            CP0_COUNT:    rdata_o = count_q;
`endif
            default:      rdata_o = '0;
        endcase
    end

    assign ie_o  = ie_q;
    assign exl_o = exl_q;
    assign epc_o = epc_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception sequencer: prioritises faults/interrupts, updates CP0, flushes the
// pipeline and redirects fetch to the handler or back to EPC on ERET.
// Optional feature macro: CP0_EXC_COUNT_EN (passed through to cp0_regfile).
module cp0_exc_ctrl
    import cp0_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    cp0_exc_ctrl_if.slave bus
);

    exc_state_e  state_q;
    logic        ie, exl;
    logic [31:0] epc;
    logic        take, eret_go;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        badv_we;

    logic        flush_d_q, flush_e_q, flush_m_q, flush_w_q, wb_dis_q;
    logic        redir_valid_q, busy_q;
    logic [31:0] redir_pc_q;

    // Exceptions are only accepted while idle and not already in a handler
    always_comb begin
        take     = (state_q == StIdle) && !exl &&
                   (bus.ex_fault || bus.id_fault || (bus.ext_irq && ie));
        eret_go  = (state_q == StIdle) && !take && bus.eret_d && exl;
        exc_code = EXC_INT;
        exc_epc  = bus.pc_d;
        badv_we  = 1'b0;
        if (bus.ex_fault) begin
            exc_code = EXC_ADES;
            exc_epc  = bus.pc_e;
            badv_we  = 1'b1;
        end else if (bus.id_fault) begin
            exc_code = EXC_DIVZ;
        end
    end

    cp0_regfile u_regfile (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .we_i       (bus.cp0_we),
        .addr_i     (bus.cp0_addr),
        .wdata_i    (bus.cp0_wdata),
        .rdata_o    (bus.cp0_rdata),
        .take_i     (take),
        .exc_code_i (exc_code),
        .epc_i      (exc_epc),
        .badv_we_i  (badv_we),
        .badv_i     (bus.ex_addr),
        .eret_i     (eret_go),
        .ie_o       (ie),
        .exl_o      (exl),
        .epc_o      (epc)
    );

    // Sequencer FSM with registered flush/redirect outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            flush_d_q     <= 1'b0;
            flush_e_q     <= 1'b0;
            flush_m_q     <= 1'b0;
            flush_w_q     <= 1'b0;
            wb_dis_q      <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (take) begin
                        state_q   <= StFlush;
                        flush_d_q <= 1'b1;
                        flush_e_q <= 1'b1;
                        flush_m_q <= 1'b1;
                        flush_w_q <= 1'b1;
                        wb_dis_q  <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (eret_go) begin
                        state_q       <= StRedirect;
                        flush_d_q     <= 1'b1;
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= epc;
                        busy_q        <= 1'b1;
                    end
                end
                StFlush: begin
                    state_q       <= StRedirect;
                    flush_e_q     <= 1'b0;
                    flush_m_q     <= 1'b0;
                    flush_w_q     <= 1'b0;
                    wb_dis_q      <= 1'b0;
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= HANDLER_ADDR;
                end
                StRedirect: begin
                    if (bus.redir_ack) begin
                        state_q       <= StIdle;
                        flush_d_q     <= 1'b0;
                        redir_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.flush_d     = flush_d_q;
    assign bus.flush_e     = flush_e_q;
    assign bus.flush_m     = flush_m_q;
    assign bus.flush_w     = flush_w_q;
    assign bus.wb_disable  = wb_dis_q;
    assign bus.redir_valid = redir_valid_q;
    assign bus.redir_pc    = redir_pc_q;
    assign bus.busy        = busy_q;

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Exception sequencer that consumes the pipeline's per-stage fault flags (ID-stage divide-by-zero, EX-stage out-of-range store) plus an external interrupt line. It owns the architected CP0 exception registers, flushes the pipeline, and redirects fetch to the handler. It also executes ERET back to EPC. It sits between the fault-detection logic and the fetch/PC-select stage.

## Interface
- HANDLER_ADDR, 32'h0000_0180: exception vector driven on redirect.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- id_fault  in  1  ID-stage divide-by-zero flag.
- ex_fault  in  1  EX-stage store address > 2047 flag.
- ex_addr  in  32  faulting EX store address.
- ext_irq  in  1  level external interrupt.
- pc_d, pc_e  in  32  PCs of instructions in ID and EX.
- eret_d  in  1  ERET decoded in ID.
- cp0_we  in  1  MTC0 write strobe.
- cp0_addr  in  5  CP0 register index (rd).
- cp0_wdata  in  32  MTC0 data.
- cp0_rdata  out  32  MFC0 data, combinational from cp0_addr.
- flush_d, flush_e, flush_m, flush_w  out  1  stage flush.
- wb_disable  out  1  block register-file writeback.
- redir_valid  out  1  PC redirect request.
- redir_pc  out  32  redirect target.
- redir_ack  in  1  fetch accepts redirect.
- busy  out  1  sequencer not IDLE; front end stalls.

## Operation
- CP0 registers: BadVAddr(8), Status(12): bit0 IE, bit1 EXL, other bits read 0. Cause(13): bits[6:2] ExcCode, others 0. EPC(14). Any other index reads 0; writes to it are dropped.
- Take condition, evaluated in IDLE only, with EXL=0. Priority is ex_fault > id_fault > (ext_irq & IE).
  - ex_fault: ExcCode=5 (AdES), EPC=pc_e, BadVAddr=ex_addr.
  - id_fault: ExcCode=13, EPC=pc_d.
  - irq: ExcCode=0, EPC=pc_d.
  - Every take sets EXL=1.
- Faults arriving with EXL=1 or outside IDLE are dropped and leave CP0 unchanged. ext_irq is level-sensitive, so it is taken later once enabled.
- FSM states:
  - IDLE: on take, go to FLUSH. Else, on eret_d with EXL=1, clear EXL, load target=EPC, go to REDIRECT. eret_d with EXL=0 is ignored.
  - FLUSH: one cycle. All flush_* and wb_disable are 1. Target=HANDLER_ADDR. Go to REDIRECT.
  - REDIRECT: redir_valid=1 and redir_pc=target held stable until redir_ack. flush_d=1 each cycle. On ack, go to IDLE.
- MTC0 is honoured in any state. If a take or ERET updates the same cycle, the hardware update wins for Status/Cause/EPC/BadVAddr.

## Timing
- Reset values: every CP0 register 0, state IDLE. All flush_*, wb_disable, redir_valid and busy are 0. redir_pc is 0.
- Fault sampled at edge T. CP0 is updated at T. FLUSH is visible in cycle T+1. REDIRECT begins at T+2.
- Minimum exception round trip is 3 cycles (ack in the first REDIRECT cycle). ERET minimum is 2 cycles.
- redir_ack outside REDIRECT is ignored.
- busy=1 in FLUSH and REDIRECT.
- rst_n low in any state returns to IDLE at the next edge and drops a pending redirect.
- cp0_rdata reflects the register value before the current edge's write; there is no write-through bypass.

## Configuration
- CP0_EXC_COUNT_EN defined:
  - Adds a 32-bit saturating counter at CP0 index 22. It increments on each take, stops at 32'hFFFF_FFFF, and resets to 0.
  - It is writable via MTC0; when a write and a take land in the same cycle, the take increment wins.
- CP0_EXC_COUNT_EN undefined: index 22 reads 0 and is not writable.

## Structure
- Shared package cp0_pkg:
  - CP0 register indices (8, 12, 13, 14, 22).
  - ExcCode constants.
  - Status bit positions.
  - FSM state enum (IDLE, FLUSH, REDIRECT).
- Natural sub-module: cp0_regfile. It holds the architected registers and the read mux, and takes write and exception-update ports. The FSM and priority logic stay in cp0_exc_ctrl.

## Test plan
- Reset, then ex_fault=1, ex_addr=32'h900, pc_e=32'h40: EPC=0x40, BadVAddr=0x900, Cause=0x14, Status=0x2. FLUSH at T+1. redir_pc=0x180 at T+2.
- ex_fault and id_fault in the same cycle, pc_d=0x44, pc_e=0x40: EPC=0x40, ExcCode=5. Only one exception is taken.
- id_fault with EXL=1: no state change, busy stays 0.
- ext_irq=1 with IE=0: no take. MTC0 Status=1: take next cycle, ExcCode=0, EPC=pc_d.
- redir_ack withheld for 4 cycles: redir_valid and redir_pc remain stable. ERET afterwards redirects to EPC and clears EXL.
- rst_n low during REDIRECT: next cycle redir_valid=0, state IDLE, all CP0 registers 0. With CP0_EXC_COUNT_EN, two takes read 2 at index 22.
